// File: rtl/accum_stack.sv
// Accumulator with a DEPTH-entry save/restore LIFO, status flags and a sticky stack-error flag.
// Push, pop and exchange are all single-cycle. Stack storage is not reset; only the occupancy count is.
module accum_stack #(
    parameter int WIDTH    = 8,
    parameter int IMM_W    = 4,
    parameter int DEPTH    = 4,
    parameter int SEXT_IMM = 0,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             CLB,
    input  logic             loadAcc,
    input  logic [1:0]       sel_acc,
    input  logic [WIDTH-1:0] alu_in,
    input  logic [WIDTH-1:0] reg_in,
    input  logic [IMM_W-1:0] imm,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             zero,
    output logic             neg,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] src;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             do_push;
    logic             do_xchg;
    logic             err_set;

    // Fill with the sign bit (or zeros) first, then overlay the raw field.
    always_comb begin
        imm_ext = ((SEXT_IMM != 0) && imm[IMM_W-1]) ? '1 : '0;
        imm_ext[IMM_W-1:0] = imm;
    end

    always_comb begin
        unique case (sel_acc)
            2'b00:   src = alu_in;
            2'b01:   src = '0;
            2'b10:   src = reg_in;
            default: src = imm_ext;
        endcase
    end

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign top_idx = IDX_W'(count - CNT_W'(1));
    assign wr_idx  = IDX_W'(count);
    assign do_push = push && !pop && !full;
    assign do_xchg = push && pop && !empty;
    assign err_set = (push && !pop && full) || (pop && empty);

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (err_set)
                err <= 1'b1;
            else if (clr_err)
                err <= 1'b0;

            // A pending pop/exchange owns Acc; loadAcc only matters on idle or push cycles.
            unique case ({push, pop})
                2'b00: if (loadAcc) acc <= src;
                2'b10: begin
                    if (!full) count <= count + CNT_W'(1);
                    if (loadAcc) acc <= src;
                end
                2'b01: if (!empty) begin
                    acc   <= stack[top_idx];
                    count <= count - CNT_W'(1);
                end
                default: if (!empty) acc <= stack[top_idx];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (CLB) begin
            if (do_push)
                stack[wr_idx] <= acc;
            else if (do_xchg)
                stack[top_idx] <= acc;
        end
    end

    assign dout = acc;
    assign zero = (acc == '0);
    assign neg  = acc[WIDTH-1];

endmodule

// File: tb/tb_accum_stack.sv
// Self-checking bench: directed scenarios plus random ops against a queue-based reference model.
module tb_accum_stack;

    localparam int WIDTH = 8;
    localparam int IMM_W = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             CLB = 1'b0;
    logic             loadAcc = 1'b0;
    logic [1:0]       sel_acc = 2'b00;
    logic [WIDTH-1:0] alu_in = '0;
    logic [WIDTH-1:0] reg_in = '0;
    logic [IMM_W-1:0] imm = '0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             clr_err = 1'b0;

    logic [WIDTH-1:0] dout, dout_s;
    logic             zero, neg, full, empty, err;
    logic             zero_s, neg_s, full_s, empty_s, err_s;
    logic [CNT_W-1:0] count, count_s;

    accum_stack #(.WIDTH(WIDTH), .IMM_W(IMM_W), .DEPTH(DEPTH), .SEXT_IMM(0)) dut (
        .clk(clk), .CLB(CLB), .loadAcc(loadAcc), .sel_acc(sel_acc), .alu_in(alu_in),
        .reg_in(reg_in), .imm(imm), .push(push), .pop(pop), .clr_err(clr_err),
        .dout(dout), .zero(zero), .neg(neg), .full(full), .empty(empty),
        .count(count), .err(err)
    );

    accum_stack #(.WIDTH(WIDTH), .IMM_W(IMM_W), .DEPTH(DEPTH), .SEXT_IMM(1)) dut_s (
        .clk(clk), .CLB(CLB), .loadAcc(loadAcc), .sel_acc(sel_acc), .alu_in(alu_in),
        .reg_in(reg_in), .imm(imm), .push(push), .pop(pop), .clr_err(clr_err),
        .dout(dout_s), .zero(zero_s), .neg(neg_s), .full(full_s), .empty(empty_s),
        .count(count_s), .err(err_s)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model for the zero-extending instance
    int unsigned      m_acc;
    bit               m_err;
    logic [WIDTH-1:0] m_stk[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit ld, input logic [1:0] sel, input logic [7:0] a,
                         input logic [7:0] r, input logic [3:0] im,
                         input bit ps, input bit pp, input bit ce);
        loadAcc = ld; sel_acc = sel; alu_in = a; reg_in = r; imm = im;
        push = ps; pop = pp; clr_err = ce;
    endtask

    function automatic int unsigned model_src();
        case (sel_acc)
            2'b00:   return alu_in;
            2'b01:   return 0;
            2'b10:   return reg_in;
            default: return imm;
        endcase
    endfunction

    task automatic model_step();
        bit set;
        logic [WIDTH-1:0] t;
        set = 0;
        if (push && !pop) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(m_acc[WIDTH-1:0]);
            else set = 1;
            if (loadAcc) m_acc = model_src();
        end else if (!push && pop) begin
            if (m_stk.size() > 0) m_acc = m_stk.pop_back();
            else set = 1;
        end else if (push && pop) begin
            if (m_stk.size() > 0) begin
                t = m_stk[m_stk.size()-1];
                m_stk[m_stk.size()-1] = m_acc[WIDTH-1:0];
                m_acc = t;
            end else set = 1;
        end else if (loadAcc) begin
            m_acc = model_src();
        end
        if (set) m_err = 1;
        else if (clr_err) m_err = 0;
    endtask

    task automatic model_reset();
        m_acc = 0; m_err = 0; m_stk.delete();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"},  dout, m_acc);
        chk({tag, ".zero"},  zero, m_acc == 0);
        chk({tag, ".neg"},   neg, m_acc[WIDTH-1]);
        chk({tag, ".count"}, count, m_stk.size());
        chk({tag, ".full"},  full, m_stk.size() == DEPTH);
        chk({tag, ".empty"}, empty, m_stk.size() == 0);
        chk({tag, ".err"},   err, m_err);
    endtask

    // Edge, update model with the inputs that were sampled, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        chk("reset.s_zero", zero_s, 1'b1);
        CLB = 1'b1;
        @(negedge clk);

        // Immediate extension on both instances
        drive(1, 2'b11, 8'h00, 8'h00, 4'hA, 0, 0, 0);
        step("imm");
        chk("imm.dout", dout, 8'h0A);
        chk("imm.neg", neg, 1'b0);
        chk("imm_sext.dout", dout_s, 8'hFA);
        chk("imm_sext.neg", neg_s, 1'b1);

        // Push two, pop two
        drive(1, 2'b10, 8'h00, 8'h11, 4'h0, 0, 0, 0); step("ld11");
        drive(0, 2'b00, 8'h00, 8'h00, 4'h0, 1, 0, 0); step("push1");
        drive(1, 2'b10, 8'h00, 8'h22, 4'h0, 0, 0, 0); step("ld22");
        drive(0, 2'b00, 8'h00, 8'h00, 4'h0, 1, 0, 0); step("push2");
        drive(0, 2'b00, 8'h00, 8'h00, 4'h0, 0, 1, 0); step("pop1");
        chk("pop1.dout", dout, 8'h22);
        chk("pop1.count", count, 1);
        step("pop2");
        chk("pop2.dout", dout, 8'h11);
        chk("pop2.empty", empty, 1'b1);
        chk("pop2.err", err, 1'b0);

        // Fill, then overflow with a concurrent load
        for (int i = 1; i <= 4; i++) begin
            drive(1, 2'b10, 8'h00, 8'(i), 4'h0, 0, 0, 0); step("fill_ld");
            drive(0, 2'b00, 8'h00, 8'h00, 4'h0, 1, 0, 0); step("fill_push");
        end
        chk("fill.full", full, 1'b1);
        drive(1, 2'b10, 8'h00, 8'h55, 4'h0, 1, 0, 0); step("ovf");
        chk("ovf.dout", dout, 8'h55);
        chk("ovf.count", count, 4);
        chk("ovf.err", err, 1'b1);
        drive(0, 2'b00, 8'h00, 8'h00, 4'h0, 0, 0, 1); step("clr");
        chk("clr.err", err, 1'b0);

        // Drain, then underflow with loadAcc ignored, clr_err in same cycle
        drive(0, 2'b00, 8'h00, 8'h00, 4'h0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step("drain");
        drive(1, 2'b00, 8'h33, 8'h00, 4'h0, 0, 1, 1); step("udf");
        chk("udf.dout", dout, 8'h01);
        chk("udf.err", err, 1'b1);

        // Exchange: Acc=80, top=7F
        drive(1, 2'b10, 8'h00, 8'h7F, 4'h0, 0, 0, 1); step("x_ld");
        drive(1, 2'b10, 8'h00, 8'h80, 4'h0, 1, 0, 0); step("x_pushld");
        drive(1, 2'b01, 8'h00, 8'h00, 4'h0, 1, 1, 0); step("xchg");
        chk("xchg.dout", dout, 8'h7F);
        drive(0, 2'b00, 8'h00, 8'h00, 4'h0, 0, 1, 0); step("x_pop");
        chk("x_pop.dout", dout, 8'h80);
        chk("x_pop.neg", neg, 1'b1);

        // Async reset between edges with count=3, Acc=C3
        drive(0, 2'b00, 8'h00, 8'h00, 4'h0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("ar_push");
        drive(1, 2'b00, 8'hC3, 8'h00, 4'h0, 0, 0, 0); step("ar_ld");
        chk("ar_pre.count", count, 3);
        drive(0, 2'b00, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        #2 CLB = 1'b0;
        #1;
        model_reset();
        chk("arst.dout", dout, 8'h00);
        chk("arst.count", count, 0);
        chk("arst.empty", empty, 1'b1);
        #2 CLB = 1'b1;
        drive(1, 2'b01, 8'hAA, 8'hAA, 4'hF, 0, 0, 0); step("post_clr");
        chk("post_clr.zero", zero, 1'b1);

        // Random ops against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), 2'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
